// File: rtl/karatsuba_seq_mult.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one Karatsuba level computing z2, z0, z1 on a
// single shared (H+1)x(H+1) multiplier, followed by one combine step.
module karatsuba_seq_mult #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   input_a_tdata,
  input  logic               input_a_tvalid,
  output logic               input_a_tready,
  input  logic [WIDTH-1:0]   input_b_tdata,
  input  logic               input_b_tvalid,
  output logic               input_b_tready,
  output logic [2*WIDTH-1:0] output_tdata,
  output logic               output_tvalid,
  input  logic               output_tready,
  output logic               busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * H + 2;
  localparam int unsigned OW = 2 * WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StMulZ2,
    StMulZ0,
    StMulZ1,
    StComb,
    StOut
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            a_held_q, b_held_q;
  logic [2*H-1:0]  z2_q, z0_q;
  logic [PW-1:0]   z1_q;
  logic [OW-1:0]   out_data_q;
  logic            out_valid_q;

  logic            a_fire, b_fire;
  logic [H:0]      a_sum, b_sum;
  logic [H:0]      mul_x, mul_y;
  logic [PW-1:0]   mul_p;
  logic [PW-1:0]   z_mid;
  logic [OW-1:0]   comb_sum;

  // Readies depend only on registered state, gated off while reset is held.
  assign input_a_tready = rst & (state_q == StIdle) & ~a_held_q;
  assign input_b_tready = rst & (state_q == StIdle) & ~b_held_q;
  assign a_fire         = input_a_tvalid & input_a_tready;
  assign b_fire         = input_b_tvalid & input_b_tready;

  assign output_tdata  = out_data_q;
  assign output_tvalid = out_valid_q;
  assign busy          = a_held_q | b_held_q;

  assign a_sum = {1'b0, a_q[WIDTH-1:H]} + {1'b0, a_q[H-1:0]};
  assign b_sum = {1'b0, b_q[WIDTH-1:H]} + {1'b0, b_q[H-1:0]};

  always_comb begin
    mul_x = a_sum;
    mul_y = b_sum;
    case (state_q)
      StMulZ2: begin
        mul_x = {1'b0, a_q[WIDTH-1:H]};
        mul_y = {1'b0, b_q[WIDTH-1:H]};
      end
      StMulZ0: begin
        mul_x = {1'b0, a_q[H-1:0]};
        mul_y = {1'b0, b_q[H-1:0]};
      end
      default: ;
    endcase
  end

  assign mul_p = {{(H + 1){1'b0}}, mul_x} * {{(H + 1){1'b0}}, mul_y};

  // z1 - z2 - z0 = aH*bL + aL*bH: never negative, and the full sum fits exactly in 2*WIDTH bits.
  assign z_mid    = z1_q - {2'b00, z2_q} - {2'b00, z0_q};
  assign comb_sum = ({{(OW - 2 * H){1'b0}}, z2_q} << WIDTH)
                  + ({{(OW - PW){1'b0}}, z_mid} << H)
                  + {{(OW - 2 * H){1'b0}}, z0_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      a_held_q    <= 1'b0;
      b_held_q    <= 1'b0;
      z2_q        <= '0;
      z0_q        <= '0;
      z1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (a_fire) begin
            a_q      <= input_a_tdata;
            a_held_q <= 1'b1;
          end
          if (b_fire) begin
            b_q      <= input_b_tdata;
            b_held_q <= 1'b1;
          end
          if ((a_held_q | a_fire) & (b_held_q | b_fire)) begin
            state_q <= StMulZ2;
          end
        end
        StMulZ2: begin
          z2_q    <= mul_p[2*H-1:0];
          state_q <= StMulZ0;
        end
        StMulZ0: begin
          z0_q    <= mul_p[2*H-1:0];
          state_q <= StMulZ1;
        end
        StMulZ1: begin
          z1_q    <= mul_p;
          state_q <= StComb;
        end
        StComb: begin
          out_data_q  <= comb_sum;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (output_tready) begin
            out_valid_q <= 1'b0;
            a_held_q    <= 1'b0;
            b_held_q    <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Scoreboard bench for karatsuba_seq_mult (WIDTH=64): directed products, latency,
// backpressure, reset mid-operation and randomised handshakes.
module tb_karatsuba_seq_mult;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   input_a_tdata, input_b_tdata;
  logic           input_a_tvalid, input_b_tvalid;
  logic           input_a_tready, input_b_tready;
  logic [2*W-1:0] output_tdata;
  logic           output_tvalid;
  logic           output_tready;
  logic           busy;

  logic           tready_set;
  logic           rand_en;
  logic           rnd_bit = 1'b0;

  logic [2*W-1:0] exp_q[$];
  vec_t           vecs[$];
  logic [W-1:0]   corners[6];
  int             total = 0;
  int             bad = 0;
  int             hs_cnt = 0;

  assign output_tready = rand_en ? rnd_bit : tready_set;

  karatsuba_seq_mult #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_a_tdata  (input_a_tdata),
    .input_a_tvalid (input_a_tvalid),
    .input_a_tready (input_a_tready),
    .input_b_tdata  (input_b_tdata),
    .input_b_tvalid (input_b_tvalid),
    .input_b_tready (input_b_tready),
    .output_tdata   (output_tdata),
    .output_tvalid  (output_tvalid),
    .output_tready  (output_tready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every product handshake pops the oldest expected value.
  always @(negedge clk) begin
    if (rst && output_tvalid && output_tready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_product: got %h want no product", output_tdata);
      end else begin
        check("product", output_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int b_delay,
                      input bit push, input logic [2*W-1:0] exp);
    int n;
    bit a_go, b_go, a_pend, b_pend;
    n      = 0;
    a_pend = 1'b1;
    b_pend = 1'b1;
    if (push) exp_q.push_back(exp);
    input_a_tdata  = a;
    input_a_tvalid = 1'b1;
    input_b_tdata  = b;
    input_b_tvalid = (b_delay == 0);
    while ((a_pend || b_pend) && n < 300) begin
      @(negedge clk);
      a_go = input_a_tvalid && input_a_tready;
      b_go = input_b_tvalid && input_b_tready;
      @(posedge clk);
      #1;
      n++;
      if (a_go) begin
        a_pend         = 1'b0;
        input_a_tvalid = 1'b0;
      end
      if (b_go) begin
        b_pend         = 1'b0;
        input_b_tvalid = 1'b0;
      end
      if (b_pend && !input_b_tvalid && n >= b_delay) input_b_tvalid = 1'b1;
    end
    if (a_pend || b_pend) begin
      total++;
      bad++;
      input_a_tvalid = 1'b0;
      input_b_tvalid = 1'b0;
      $display("FAIL send_timeout: pending a=%0d b=%0d want 0 0", a_pend, b_pend);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs_before;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] bp_exp;

    rst            = 1'b0;
    input_a_tdata  = '0;
    input_b_tdata  = '0;
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    tready_set     = 1'b1;
    rand_en        = 1'b0;
    corners[0] = 64'h0;
    corners[1] = 64'h1;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'hFFFF_FFFF;
    corners[5] = 64'h8000_0000_8000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", 128'(output_tvalid), 128'd0);
    check("rst_tdata", output_tdata, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_readies", 128'({input_a_tready, input_b_tready}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_readies", 128'({input_a_tready, input_b_tready}), 128'd3);

    // 3*5 on the same edge: valid exactly in the cycle after E0+4, for one cycle
    @(posedge clk);
    #1;
    send(64'd3, 64'd5, 0, 1'b1, 128'd15);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("lat_tvalid_%0d", k), 128'(output_tvalid), 128'(k == 4));
      if (k == 0) check("lat_busy", 128'(busy), 128'd1);
      @(posedge clk);
    end
    #1;

    // Directed vectors, hand-computed products
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
    vecs.push_back('{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0});
    vecs.push_back('{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h2, 128'h0000_0000_0000_0001_0000_0000_0000_0000});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001});
    vecs.push_back('{64'h1_0000_0000, 64'hFFFF_FFFF, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                     128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{64'h1234, 64'h10, 128'h12340});
    vecs.push_back('{64'h8000_0000, 64'h8000_0000, 128'h0000_0000_0000_0000_4000_0000_0000_0000});
    vecs.push_back('{64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000,
                     128'h4000_0000_8000_0000_4000_0000_0000_0000});
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, i % 3, 1'b1, vecs[i].p);
    drain(200);

    // Staggered capture, then 10 cycles of backpressure
    tready_set = 1'b0;
    bp_exp     = 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFD;
    exp_q.push_back(bp_exp);
    input_a_tdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    input_a_tvalid = 1'b1;
    @(posedge clk);
    #1;
    input_a_tvalid = 1'b0;
    @(negedge clk);
    check("stag_a_ready", 128'(input_a_tready), 128'd0);
    check("stag_b_ready", 128'(input_b_tready), 128'd1);
    check("stag_busy", 128'(busy), 128'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    input_b_tdata  = 64'h3;
    input_b_tvalid = 1'b1;
    @(posedge clk);
    #1;
    input_b_tvalid = 1'b0;
    n = 0;
    while (!output_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_tvalid_rise", 128'(output_tvalid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      input_a_tdata  = 64'hDEAD;
      input_a_tvalid = (i == 4);
      @(negedge clk);
      check("bp_tvalid", 128'(output_tvalid), 128'd1);
      check("bp_tdata", output_tdata, bp_exp);
      check("bp_readies", 128'({input_a_tready, input_b_tready}), 128'd0);
    end
    hs_before = hs_cnt;
    @(posedge clk);
    #1;
    input_a_tvalid = 1'b0;
    tready_set     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_tvalid_fall", 128'(output_tvalid), 128'd0);
    check("bp_handshakes", 128'(hs_cnt - hs_before), 128'd1);
    check("bp_readies_back", 128'({input_a_tready, input_b_tready}), 128'd3);
    @(posedge clk);
    #1;

    // Reset while in MUL_Z1 (output_tdata still holds the previous product)
    send(64'd7, 64'd9, 0, 1'b0, 128'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tvalid", 128'(output_tvalid), 128'd0);
    check("midrst_tdata", output_tdata, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_readies", 128'({input_a_tready, input_b_tready}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(64'h1_0000_0000, 64'h1_0000_0000, 0, 1'b1, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    drain(200);

    // Random operands with random tvalid gaps and random output_tready
    rand_en = 1'b1;
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 5)];
      else ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 5)];
      else rb = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb, int'($urandom_range(0, 3)), 1'b1, {64'b0, ra} * {64'b0, rb});
    end
    drain(3000);
    rand_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
